pulse_count_latch: RTL and testbench
====================================

Name: pulse_count_latch

Overview:
Downstream stage of the 6-bit fast pulse counter. It consumes the counter's low word and its one-cycle carry pulse, and extends them into a 32-bit running total. On each latch strobe it snapshots the total, outputs the difference since the previous strobe (pulses per gate window), and hands the result to the readout path over a valid/ready handshake.

Parameters:
LOW_W, 6, width of the fast counter word (count_in)
HIGH_W, 26, width of the carry-extension counter; total width TOT_W = LOW_W + HIGH_W = 32

Ports:
clk  input  1  system clock; same clock as the fast counter
reset  input  1  asynchronous, active-high reset
count_in  input  LOW_W  fast counter value, free-running, no reset in source
cout_in  input  1  carry pulse; high for exactly one cycle, coincident with the first cycle count_in == all-ones
latch  input  1  gate-end strobe; one sample per cycle high
data_out  output  TOT_W  pulse count since previous accepted latch
valid  output  1  data_out holds an unconsumed result
ready  input  1  readout accepts data_out when valid & ready
overrun  output  1  sticky: a result was lost to backpressure

Behaviour:
- Reset (async, active-high) clears: high_cnt=0, pending=0, baseline=0, primed=0, data_out=0, valid=0, overrun=0.
- high_cnt: increments modulo 2^HIGH_W on every edge where cout_in=1.
- pending:
  - Set on an edge with cout_in=1.
  - Cleared on an edge with count_in != all-ones.
  - cout_in only occurs while count_in is all-ones, so set and clear never coincide.
- Composite (combinational): total = ((high_cnt - (pending & count_in==all-ones)) << LOW_W) | count_in.
  - The correction prevents double counting while the fast counter stalls at all-ones after its carry has already been absorbed.
  - total is exact in every cycle, including the cout_in cycle itself.
- Latch handling, for an edge where latch=1:
  - primed=0: baseline <= total, primed <= 1, no output. The first latch after reset only establishes the baseline, because the fast counter has no reset.
  - primed=1: data_out <= total - baseline (mod 2^TOT_W), baseline <= total, valid <= 1.
  - Latency: latch sampled at edge n; data_out/valid update at edge n.
- Handshake:
  - valid clears on the edge where valid & ready, unless a new result loads on the same edge, in which case valid stays 1 with the new data.
  - data_out is stable while valid & !ready.
- Overrun:
  - A primed latch while valid=1 and ready=0 sets overrun. It is sticky until reset.
  - The new result still overwrites data_out (newest wins), and baseline advances, so later deltas stay correct.
- Latch held high for k cycles produces k results: one per edge, each delta covering a single cycle.
- Wrap-around: total wraps at 2^32. Modular subtraction gives a correct delta for up to 2^32-1 pulses per window.
- Reset mid-operation: all state clears immediately, and any pending result is dropped. The next latch re-primes the baseline.
- Simultaneous cout_in and latch: the snapshot uses that cycle's composite total (count_in = all-ones, uncorrected). The high_cnt increment is taken on the same edge.

Decomposition:
- Shared package: LOW_W, HIGH_W, TOT_W constants and the all-ones low-word constant (also used by the fast counter).
- One natural sub-module: count_extender. It holds high_cnt and pending and produces total; its ports are clk, reset, count_in, cout_in, total. The latch/delta/handshake logic stays in the top.

Test Plan:
1. Reset, then latch with count_in=10 -> no valid. Drive 25 pulses, latch -> valid=1, data_out=25.
2. Step count_in 60..63 with cout_in at 63, hold at 63 for 5 cycles, then 0..4; latch before and after -> data_out=9. total stays 63+64*high with no double count during the stall.
3. Latch exactly in the cout_in cycle at count_in=63 after baseline 60 -> data_out=3. Next latch at count_in=2 -> data_out=3.
4. Hold ready=0: two primed latches 10 cycles apart -> overrun=1, data_out equals the second delta. Raise ready -> valid clears next edge, overrun stays 1.
5. Assert reset mid-window with valid=1 -> valid=0, data_out=0, overrun=0 immediately. The first latch after release produces no output.
6. Preload baseline near 2^32-3 via 2^26 carries (or forced high_cnt), then 10 pulses -> data_out=10 across the wrap.

Source files
------------

// File: rtl/pulse_count_latch_pkg.sv
// Shared widths and constants for the fast pulse counter and its latch stage.
package pulse_count_latch_pkg;

  localparam int unsigned LOW_W  = 6;
  localparam int unsigned HIGH_W = 26;
  localparam int unsigned TOT_W  = LOW_W + HIGH_W;

  localparam logic [LOW_W-1:0] LOW_ONES = '1;

  typedef enum logic {
    ST_UNPRIMED,
    ST_PRIMED
  } latch_state_t;

endpackage

// File: rtl/pulse_count_latch_if.sv
// Readout handshake carrying the per-window pulse count.
interface pulse_count_latch_if;
  import pulse_count_latch_pkg::*;

  logic [TOT_W-1:0] data_out;
  logic             valid;
  logic             ready;
  logic             overrun;

  modport master (
    output data_out,
    output valid,
    output overrun,
    input  ready
  );

  modport slave (
    input  data_out,
    input  valid,
    input  overrun,
    output ready
  );
endinterface

// File: rtl/pulse_count_latch_count_extender.sv
// Extends the 6-bit fast counter into a 32-bit running total using its carry pulse.
module count_extender
  import pulse_count_latch_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [LOW_W-1:0] count_in,
  input  logic             cout_in,
  output logic [TOT_W-1:0] total
);

  logic [HIGH_W-1:0] high_cnt;
  logic [HIGH_W-1:0] high_eff;
  logic              pending;
  logic              at_ones;

  assign at_ones = (count_in == LOW_ONES);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      high_cnt <= '0;
      pending  <= 1'b0;
    end else begin
      if (cout_in) begin
        high_cnt <= high_cnt + HIGH_W'(1);
        pending  <= 1'b1;
      end else if (!at_ones) begin
        pending  <= 1'b0;
      end
    end
  end

  // Carry already absorbed into high_cnt while the low word still sits at all-ones.
  always_comb begin
    high_eff = high_cnt - HIGH_W'(pending & at_ones);
    total    = {high_eff, count_in};
  end

endmodule

// File: rtl/pulse_count_latch.sv
// Snapshots the running pulse total on each latch strobe and hands out the delta.
module pulse_count_latch
  import pulse_count_latch_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LOW_W-1:0]        count_in,
  input  logic                    cout_in,
  input  logic                    latch,
  pulse_count_latch_if.master     rd
);

  latch_state_t     state_q, state_d;
  logic [TOT_W-1:0] total;
  logic [TOT_W-1:0] baseline;
  logic             load;

  count_extender u_ext (
    .clk      (clk),
    .reset    (reset),
    .count_in (count_in),
    .cout_in  (cout_in),
    .total    (total)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_UNPRIMED;
    else       state_q <= state_d;
  end

  // First latch only primes the baseline; the fast counter has no reset.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    if (latch) begin
      if (state_q == ST_PRIMED) load    = 1'b1;
      else                      state_d = ST_PRIMED;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baseline    <= '0;
      rd.data_out <= '0;
      rd.valid    <= 1'b0;
      rd.overrun  <= 1'b0;
    end else begin
      if (latch) baseline <= total;
      if (load) begin
        rd.data_out <= total - baseline;
        rd.valid    <= 1'b1;
        if (rd.valid && !rd.ready) rd.overrun <= 1'b1;
      end else if (rd.valid && rd.ready) begin
        rd.valid    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_count_latch.sv
// Bench for pulse_count_latch: directed scenarios plus random pulses/latches vs a pulse-total model.
module tb_pulse_count_latch;
  import pulse_count_latch_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic [LOW_W-1:0] count_in;
  logic             cout_in;
  logic             latch;

  pulse_count_latch_if rd_if ();

  pulse_count_latch dut (
    .clk      (clk),
    .reset    (reset),
    .count_in (count_in),
    .cout_in  (cout_in),
    .latch    (latch),
    .rd       (rd_if)
  );

  always #5 clk = ~clk;

  // Model: m_tot is the true number of pulses seen (plus the counter's value at reset).
  logic [31:0] m_tot, m_base, m_data;
  bit          m_primed, m_valid, m_ovr;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"},   32'(rd_if.valid),   32'(m_valid));
    chk({tag, ".data"},    rd_if.data_out,     m_data);
    chk({tag, ".overrun"}, 32'(rd_if.overrun), 32'(m_ovr));
  endtask

  task automatic step(input bit pulse, input bit lat, input bit rdy, input string tag);
    @(negedge clk);
    if (pulse) m_tot = m_tot + 32'd1;
    count_in    = m_tot[LOW_W-1:0];
    cout_in     = pulse && (m_tot[LOW_W-1:0] == LOW_ONES);
    latch       = lat;
    rd_if.ready = rdy;
    if (lat && m_primed) begin
      if (m_valid && !rdy) m_ovr = 1'b1;
      m_data  = m_tot - m_base;
      m_valid = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (lat) begin
      m_base   = m_tot;
      m_primed = 1'b1;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    latch   = 1'b0;
    cout_in = 1'b0;
    #2 reset = 1'b1;
    #1;
    m_tot    = {26'd0, m_tot[LOW_W-1:0]};
    m_base   = '0;
    m_data   = '0;
    m_primed = 1'b0;
    m_valid  = 1'b0;
    m_ovr    = 1'b0;
    check_all("reset_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic advance_to(input logic [LOW_W-1:0] target);
    for (int i = 0; i < 64 && m_tot[LOW_W-1:0] != target; i++) step(1'b1, 1'b0, 1'b1, "adv");
  endtask

  initial begin
    m_tot = 32'd10; m_base = '0; m_data = '0;
    m_primed = 1'b0; m_valid = 1'b0; m_ovr = 1'b0;
    reset = 1'b1; count_in = 6'd10; cout_in = 1'b0; latch = 1'b0; rd_if.ready = 1'b1;
    #1 check_all("reset_init");
    @(negedge clk);
    reset = 1'b0;

    // 1: priming latch, then 25 pulses
    step(1'b0, 1'b1, 1'b1, "t1_prime");
    chk("t1_prime_novalid", 32'(rd_if.valid), 32'd0);
    for (int i = 0; i < 25; i++) step(1'b1, 1'b0, 1'b1, "t1_pulse");
    step(1'b0, 1'b1, 1'b1, "t1_latch");
    chk("t1_delta25", rd_if.data_out, 32'd25);

    // 2: carry with stall at all-ones
    advance_to(6'd59);
    step(1'b0, 1'b1, 1'b1, "t2_base");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, "t2_up");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, "t2_stall");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, "t2_wrap");
    step(1'b1, 1'b1, 1'b1, "t2_latch");
    chk("t2_delta9", rd_if.data_out, 32'd9);

    // 3: latch in the carry cycle
    advance_to(6'd59);
    step(1'b1, 1'b1, 1'b1, "t3_base");
    step(1'b1, 1'b0, 1'b1, "t3_up");
    step(1'b1, 1'b0, 1'b1, "t3_up");
    step(1'b1, 1'b1, 1'b1, "t3_cout_latch");
    chk("t3_delta_cout", rd_if.data_out, 32'd3);
    step(1'b1, 1'b0, 1'b1, "t3_up2");
    step(1'b1, 1'b0, 1'b1, "t3_up2");
    step(1'b1, 1'b1, 1'b1, "t3_latch2");
    chk("t3_delta_after", rd_if.data_out, 32'd3);

    // 4: backpressure overrun
    step(1'b0, 1'b0, 1'b1, "t4_drain");
    step(1'b1, 1'b1, 1'b0, "t4_first");
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, "t4_hold");
    step(1'b1, 1'b1, 1'b0, "t4_second");
    chk("t4_overrun", 32'(rd_if.overrun), 32'd1);
    chk("t4_newest", rd_if.data_out, 32'd11);
    step(1'b0, 1'b0, 1'b1, "t4_accept");
    chk("t4_valid_clr", 32'(rd_if.valid), 32'd0);
    chk("t4_sticky", 32'(rd_if.overrun), 32'd1);

    // 5: reset mid-window with a pending result
    step(1'b1, 1'b1, 1'b0, "t5_load");
    do_reset();
    step(1'b0, 1'b1, 1'b1, "t5_reprime");
    chk("t5_no_output", 32'(rd_if.valid), 32'd0);

    // 6: 32-bit wrap of the running total
    advance_to(6'd61);
    @(negedge clk);
    latch   = 1'b0;
    cout_in = 1'b0;
    force dut.u_ext.high_cnt = '1;
    @(posedge clk);
    @(negedge clk);
    release dut.u_ext.high_cnt;
    m_tot = {26'h3FF_FFFF, m_tot[LOW_W-1:0]};
    step(1'b0, 1'b1, 1'b1, "t6_base");
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b1, "t6_pulse");
    step(1'b1, 1'b1, 1'b1, "t6_latch");
    chk("t6_delta_wrap", rd_if.data_out, 32'd10);

    // Random traffic, including held latches and stalls
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1, "rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
